divisor_sched: RTL and testbench
================================

# divisor_sched

Run controller for the frequency-divider path. It accepts a divide ratio and an optional pulse count through a valid/ready configuration port, then generates the divided clock `clk_output` from `clk_intput`. Start/stop sequencing is glitch-free: ratio changes apply only at output-period boundaries, and a stop request always completes the current period. Sits between the control logic (FSM or host registers) and every consumer of the divided clock or its `tick` strobe.

## Interface
- `CNT_W`, 16: width of divide ratio and period counter.
- `DEF_DIV`, 4: divide ratio loaded at reset (must be ≥2).
- `PCNT_W`, 8: width of pulse-count field.

Ports:
- `clk_intput` in 1: single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cfg_valid` in 1: configuration offered.
- `cfg_ready` out 1: configuration can be accepted.
- `cfg_div` in CNT_W: divide ratio N. The output period is N input cycles.
- `cfg_pulses` in PCNT_W: number of output periods per run. 0 means continuous.
- `start` in 1: begin a run (level sampled, honoured in IDLE only).
- `stop` in 1: request end of a continuous or counted run.
- `clk_output` out 1: divided clock (registered).
- `tick` out 1: one-cycle strobe on the first input cycle of every output period.
- `busy` out 1: state is RUN or DRAIN.
- `done` out 1: one-cycle pulse when a run ends.
- `err` out 1: one-cycle pulse when a config with `cfg_div` < 2 is rejected.

## Operation
- Registers:
  - active ratio `div_a` and active pulse count `pls_a`;
  - one-entry shadow `div_s`/`pls_s` with `shadow_full` flag;
  - period counter `cnt` (0..div_a-1);
  - periods-emitted counter `pcnt`.
- States:
  - IDLE: `cfg_ready`=1. An accepted config writes the active registers directly. `start` → RUN.
  - RUN: `cfg_ready` = !`shadow_full`. An accepted config writes the shadow. End of the last counted period → IDLE. `stop` → DRAIN.
  - DRAIN: `cfg_ready`=0. The current period completes, then → IDLE.
- Handshake: a transfer occurs in a cycle where `cfg_valid` && `cfg_ready`. A config with `cfg_div` < 2 is consumed (ready stays as defined), `err` pulses the next cycle, and no register changes.
- Waveform:
  - `clk_output` is high while `cnt` < floor(div_a/2) and low otherwise.
  - N=4 gives 1100. N=3 gives 100. N=2 gives 10.
- Period boundary: `cnt` = div_a-1 in RUN.
  - `cnt` wraps to 0, `tick` asserts, and `pcnt` increments.
  - If `shadow_full`, the shadow moves to the active registers, `pcnt` clears, and `shadow_full` clears.
- Counted run: when `pls_a` ≠ 0 and the period numbered `pls_a` ends, go to IDLE with `clk_output`=0 and pulse `done`.
- Arithmetic:
  - `cnt` and `pcnt` never exceed their active limits.
  - `pcnt` saturates in continuous mode (no wrap is observable).

## Timing
- Reset values, effective the cycle after `reset` is sampled high, from any state:
  - state IDLE, `div_a`=DEF_DIV, `pls_a`=0;
  - shadow empty, `cnt`=0, `pcnt`=0;
  - `clk_output`=0, `tick`=0, `busy`=0, `done`=0, `err`=0, `cfg_ready`=1.
- A run in progress is abandoned with no `done`.
- `start` sampled in IDLE at edge k:
  - In cycle k+1: state RUN, `cnt`=0, `clk_output`=1, `tick`=1, `busy`=1.
  - Latency from `start` to the first output high is 1 cycle.
- `tick` coincides with the rising edge of `clk_output`, every div_a cycles.
- `start` with an accepted config in the same IDLE cycle: the new config governs that run.
- `stop` sampled in RUN: DRAIN begins. IDLE, `done`, and `clk_output`=0 come in the cycle after the current period ends.
- `stop` in the same cycle as the last counted period ends: a single `done` pulse and no DRAIN.
- `stop` or `start` in DRAIN: ignored. `start` in RUN: ignored. `stop` in IDLE: ignored.
- Config in the last cycle of a period in RUN: the shadow loads, and the new ratio applies at the following boundary, not the current one.
- The shadow pending when the run ends is promoted to active in IDLE.

## Test plan
- Reset, default config, `start` (DEF_DIV=4, continuous) → `clk_output` 1100 repeating, `tick` every 4 cycles, `busy`=1, no `done`.
- Config N=5, pulses=3, `start` → `clk_output` 11000 ×3 (15 cycles). `done` in cycle 16, then `busy`=0 and `clk_output`=0.
- Continuous N=6, `stop` asserted at `cnt`=2 → period completes (cnt 3..5), then `done`. No partial period.
- In RUN with N=4, config N=2 given mid-period, second config offered → the second is held (`cfg_ready`=0). Ratio switches to 10 exactly at the next boundary. The held config is taken afterwards.
- Config `cfg_div`=1 → `err` pulses once and the ratio is unchanged (waveform still 1100).
- `reset` mid-RUN at `cnt`=2 → next cycle all outputs are at reset values. A subsequent `start` runs with DEF_DIV.

Source files
------------

// File: rtl/divisor_sched_if.sv
// Configuration, run-control and divided-clock signals of the divisor_sched block.
interface divisor_sched_if #(
  parameter int CNT_W  = 16,
  parameter int PCNT_W = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CNT_W-1:0]  cfg_div;
  logic [PCNT_W-1:0] cfg_pulses;
  logic              start;
  logic              stop;
  logic              clk_output;
  logic              tick;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output cfg_valid, cfg_div, cfg_pulses, start, stop,
    input  cfg_ready, clk_output, tick, busy, done, err
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_pulses, start, stop,
    output cfg_ready, clk_output, tick, busy, done, err
  );
endinterface

// File: rtl/divisor_sched.sv
// Run controller for the frequency divider: takes a ratio and an optional
// pulse count, produces a glitch-free divided clock with a period-start
// tick, and only changes ratio or stops at output-period boundaries.
module divisor_sched #(
  parameter int CNT_W   = 16,
  parameter int DEF_DIV = 4,
  parameter int PCNT_W  = 8
) (
  input  logic clk_intput,
  input  logic reset,
  divisor_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0]  DEF_DIV_V = CNT_W'(DEF_DIV);
  localparam logic [PCNT_W-1:0] PCNT_MAX  = '1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  div_a_q, div_a_d, div_s_q, div_s_d, cnt_q, cnt_d;
  logic [PCNT_W-1:0] pls_a_q, pls_a_d, pls_s_q, pls_s_d, pcnt_q, pcnt_d;
  logic              shadow_full_q, shadow_full_d;
  logic              clk_out_q, clk_out_d;
  logic              tick_q, tick_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic cfg_ready, cfg_fire, cfg_ok, boundary, last_period, running_d;

  // In RUN the ready line is the free/full state of the one-entry shadow.
  assign cfg_ready   = (state_q == IDLE) || ((state_q == RUN) && !shadow_full_q);
  assign cfg_fire    = bus.cfg_valid && cfg_ready;
  assign cfg_ok      = bus.cfg_div >= CNT_W'(2);
  assign boundary    = (cnt_q == div_a_q - CNT_W'(1));
  assign last_period = (pls_a_q != '0) && ((pcnt_q + PCNT_W'(1)) == pls_a_q);

  // Next-state, counters, config capture and registered outputs.
  always_comb begin
    state_d       = state_q;
    div_a_d       = div_a_q;
    pls_a_d       = pls_a_q;
    div_s_d       = div_s_q;
    pls_s_d       = pls_s_q;
    shadow_full_d = shadow_full_q;
    cnt_d         = cnt_q;
    pcnt_d        = pcnt_q;
    done_d        = 1'b0;
    err_d         = cfg_fire && !cfg_ok;

    case (state_q)
      IDLE: begin
        // A shadow left over from a finished run becomes active here; a
        // config arriving now is newer and therefore wins.
        if (shadow_full_q) begin
          div_a_d       = div_s_q;
          pls_a_d       = pls_s_q;
          shadow_full_d = 1'b0;
        end
        if (cfg_fire && cfg_ok) begin
          div_a_d = bus.cfg_div;
          pls_a_d = bus.cfg_pulses;
        end
        cnt_d  = '0;
        pcnt_d = '0;
        if (bus.start) state_d = RUN;
      end

      RUN, DRAIN: begin
        if (cfg_fire && cfg_ok) begin
          div_s_d       = bus.cfg_div;
          pls_s_d       = bus.cfg_pulses;
          shadow_full_d = 1'b1;
        end
        if ((state_q == RUN) && bus.stop) state_d = DRAIN;

        if (boundary) begin
          cnt_d = '0;
          if (last_period || (state_q == DRAIN) || bus.stop) begin
            state_d = IDLE;
            done_d  = 1'b1;
            pcnt_d  = '0;
          end else begin
            pcnt_d = (pcnt_q == PCNT_MAX) ? pcnt_q : pcnt_q + PCNT_W'(1);
            if (shadow_full_q) begin
              div_a_d       = div_s_q;
              pls_a_d       = pls_s_q;
              pcnt_d        = '0;
              shadow_full_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    running_d = (state_d != IDLE);
    clk_out_d = running_d && (cnt_d < (div_a_d >> 1));
    tick_d    = running_d && (cnt_d == '0);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_intput) begin
    if (reset) begin
      state_q       <= IDLE;
      div_a_q       <= DEF_DIV_V;
      pls_a_q       <= '0;
      div_s_q       <= '0;
      pls_s_q       <= '0;
      shadow_full_q <= 1'b0;
      cnt_q         <= '0;
      pcnt_q        <= '0;
      clk_out_q     <= 1'b0;
      tick_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_a_q       <= div_a_d;
      pls_a_q       <= pls_a_d;
      div_s_q       <= div_s_d;
      pls_s_q       <= pls_s_d;
      shadow_full_q <= shadow_full_d;
      cnt_q         <= cnt_d;
      pcnt_q        <= pcnt_d;
      clk_out_q     <= clk_out_d;
      tick_q        <= tick_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign bus.cfg_ready  = cfg_ready;
  assign bus.clk_output = clk_out_q;
  assign bus.tick       = tick_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_divisor_sched.sv
// Scoreboard bench for divisor_sched: a run-level reference model predicts
// every cycle's outputs, a separate monitor compares them against the DUT.
module tb_divisor_sched;

  localparam int CNT_W   = 16;
  localparam int PCNT_W  = 8;
  localparam int DEF_DIV = 4;

  logic clk;
  logic reset;

  divisor_sched_if #(.CNT_W(CNT_W), .PCNT_W(PCNT_W)) bus_if ();

  divisor_sched #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV), .PCNT_W(PCNT_W)) dut (
    .clk_intput(clk),
    .reset     (reset),
    .bus       (bus_if)
  );

  typedef struct {
    int cyc;
    bit clk_o;
    bit tick;
    bit busy;
    bit done;
    bit err;
    bit ready;
  } exp_t;

  exp_t sb_q[$];
  int   cyc_count    = 0;
  int   total_checks = 0;
  int   fail_count   = 0;

  // Reference model: a run is described by its ratio, pulse limit, position
  // inside the current period, periods finished, and at most one pending config.
  bit m_busy, m_stopping, m_pend, m_accepted;
  int m_ratio, m_limit, m_pos, m_periods, m_pend_ratio, m_pend_limit;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges so each expectation knows which cycle it belongs to.
  always @(posedge clk) cyc_count <= cyc_count + 1;

  // Watchdog against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic model_step(input bit rst, input bit v, input int d, input int p,
                            input bit st, input bit sp);
    exp_t e;
    bit   ready_now, good, had_pend;
    e.cyc  = cyc_count + 1;
    e.tick = 1'b0;
    e.done = 1'b0;
    e.err  = 1'b0;
    m_accepted = 1'b0;
    if (rst) begin
      m_busy = 0; m_stopping = 0; m_pend = 0;
      m_ratio = DEF_DIV; m_limit = 0; m_pos = 0; m_periods = 0;
    end else begin
      ready_now  = !m_busy || (!m_stopping && !m_pend);
      m_accepted = v && ready_now;
      good       = m_accepted && (d >= 2);
      e.err      = m_accepted && !good;
      if (!m_busy) begin
        if (m_pend) begin
          m_ratio = m_pend_ratio; m_limit = m_pend_limit; m_pend = 0;
        end
        if (good) begin
          m_ratio = d; m_limit = p;
        end
        m_pos = 0; m_periods = 0;
        if (st) begin
          m_busy = 1; m_stopping = 0; e.tick = 1;
        end
      end else begin
        had_pend = m_pend;
        if (m_pos == m_ratio - 1) begin
          if ((m_limit != 0 && m_periods + 1 == m_limit) || m_stopping || sp) begin
            m_busy = 0; m_stopping = 0; e.done = 1; m_pos = 0; m_periods = 0;
          end else begin
            m_pos = 0; e.tick = 1;
            if (had_pend) begin
              m_ratio = m_pend_ratio; m_limit = m_pend_limit; m_pend = 0; m_periods = 0;
            end else if (m_periods < 255) begin
              m_periods++;
            end
          end
        end else begin
          m_pos++;
          if (sp) m_stopping = 1;
        end
        if (good) begin
          m_pend = 1; m_pend_ratio = d; m_pend_limit = p;
        end
      end
    end
    e.busy  = m_busy;
    e.clk_o = m_busy && (m_pos < m_ratio / 2);
    e.ready = !m_busy || (!m_stopping && !m_pend);
    sb_q.push_back(e);
  endtask

  task automatic applyStimulus(input bit rst, input bit v, input int d, input int p,
                               input bit st, input bit sp);
    reset              = rst;
    bus_if.cfg_valid   = v;
    bus_if.cfg_div     = CNT_W'(d);
    bus_if.cfg_pulses  = PCNT_W'(p);
    bus_if.start       = st;
    bus_if.stop        = sp;
    model_step(rst, v, d, p, st, sp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_pos(input int pos);
    for (int i = 0; i < 40 && m_pos != pos; i++) idle(1);
  endtask

  task automatic checkOutput(input string name, input logic act, input bit exp_v, input int cyc);
    total_checks++;
    if (act !== logic'(exp_v)) begin
      fail_count++;
      $display("[TB] FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp_v);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; pop the matching
  // expectation and compare field by field.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc_count) begin
        e = sb_q.pop_front();
        if (e.cyc < cyc_count) begin
          total_checks++;
          fail_count++;
          $display("[TB] FAIL stale_entry: got cycle %0d expected cycle %0d", cyc_count, e.cyc);
        end else begin
          checkOutput("clk_output", bus_if.clk_output, e.clk_o, e.cyc);
          checkOutput("tick",       bus_if.tick,       e.tick,  e.cyc);
          checkOutput("busy",       bus_if.busy,       e.busy,  e.cyc);
          checkOutput("done",       bus_if.done,       e.done,  e.cyc);
          checkOutput("err",        bus_if.err,        e.err,   e.cyc);
          checkOutput("cfg_ready",  bus_if.cfg_ready,  e.ready, e.cyc);
        end
      end
    end
  end

  // Directed scenarios followed by a randomized soak.
  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    idle(2);

    $display("[TB] default ratio, continuous run");
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(14);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(8);

    $display("[TB] counted run N=5 pulses=3");
    applyStimulus(0, 1, 5, 3, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(20);

    $display("[TB] continuous N=6 with stop at cnt=2");
    applyStimulus(0, 1, 6, 0, 1, 0);
    idle(7);
    wait_pos(2);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(8);

    $display("[TB] ratio change at boundary with held second config");
    applyStimulus(0, 1, 4, 0, 1, 0);
    idle(1);
    applyStimulus(0, 1, 2, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 3, 0, 0, 0);
      if (m_accepted) break;
    end
    idle(12);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(8);

    $display("[TB] rejected ratio 1");
    applyStimulus(0, 1, 4, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(5);
    applyStimulus(0, 1, 0, 2, 0, 0);
    idle(9);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(8);

    $display("[TB] reset in the middle of a run");
    applyStimulus(0, 1, 7, 0, 1, 0);
    idle(3);
    wait_pos(2);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0);
    idle(10);
    applyStimulus(0, 0, 0, 0, 0, 1);
    idle(6);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 299) == 0),
                    ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 4)),
                    ($urandom_range(0, 5) == 0),
                    ($urandom_range(0, 19) == 0));
    end
    idle(3);

    @(negedge clk);
    #1;
    total_checks++;
    if (sb_q.size() != 0) begin
      fail_count++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", total_checks, fail_count);
    $finish;
  end

endmodule
